// File: rtl/mealy_pkg.sv
//------------------------------------------------------------------------------
// mealy_pkg : shared types and helpers for the Mealy sequence detector
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

package mealy_pkg;

    localparam int MAX_PAT_LEN = 32;
    localparam int MAX_STATE_W = 5;

    typedef logic [MAX_STATE_W-1:0] state_t;
    typedef logic [MAX_PAT_LEN-1:0] pattern_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Next state after the k matched pattern bits are followed by bit b: the
    // longest pattern prefix that is also a suffix of that string, capped at
    // pat_len-1 so a full match falls back to the longest proper border.
    function automatic state_t kmp_next(
        input state_t   k,
        input logic     b,
        input pattern_t pat,
        input int       pat_len,
        input bit       overlap
    );
        state_t res;
        bit     found;
        bit     ok;
        int     len;
        int     start;
        int     idx;
        logic   s_bit;
        res   = '0;
        found = 1'b0;
        len   = int'(k) + 1;
        for (int j = MAX_PAT_LEN - 1; j >= 1; j--) begin
            if (!found && (j <= len) && (j < pat_len)) begin
                ok    = 1'b1;
                start = len - j;
                for (int i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < j) begin
                        idx   = start + i;
                        s_bit = (idx < int'(k)) ? pat[5'(pat_len - 1 - idx)] : b;
                        if (pat[5'(pat_len - 1 - i)] != s_bit) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res   = state_t'(j);
                    found = 1'b1;
                end
            end
        end
        if (!overlap && (int'(k) == pat_len - 1) && (b == pat[0])) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mealy_next_state.sv
//------------------------------------------------------------------------------
// mealy_next_state : combinational (state, din) -> (nextState, hit) transition logic
// Rev 1.0          : initial release
//------------------------------------------------------------------------------
`default_nettype none

module mealy_next_state
    import mealy_pkg::*;
#(
    parameter int               PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b001,
    parameter bit               OVERLAP = 1'b1,
    localparam int              SW      = clog2(PAT_LEN)
) (
    input  logic [SW-1:0] state,
    input  logic          din,
    output logic [SW-1:0] nextState,
    output logic          hit
);

    pattern_t w_pattern;
    assign w_pattern = pattern_t'(PATTERN);

    always_comb begin
        nextState = SW'(kmp_next(state_t'(state), din, w_pattern, PAT_LEN, OVERLAP));
        hit       = (state == SW'(PAT_LEN - 1)) && (din == PATTERN[0]);
    end

endmodule

`default_nettype wire

// File: rtl/mealy_seq_detector.sv
//------------------------------------------------------------------------------
// mealy_seq_detector : Mealy FSM serial pattern detector (default "001", overlapping)
// Optional MEALY_DET_COUNT_EN adds a saturating detection counter on det_count.
// Rev 1.0            : initial release
//------------------------------------------------------------------------------
`default_nettype none

module mealy_seq_detector
    import mealy_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b001,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
`ifdef MEALY_DET_COUNT_EN
    output logic [CNT_W-1:0] det_count,
`endif
    output logic             y
);

    localparam int SW = clog2(PAT_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] nextState;
    logic          hit;

    mealy_next_state #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_next_state (
        .state     (state),
        .din       (din),
        .nextState (nextState),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= nextState;
        end
    end

    // Mealy output: valid before the edge that consumes the final bit.
    assign y = hit & ~reset;

`ifdef MEALY_DET_COUNT_EN
    logic [CNT_W-1:0] det_count_q;
    logic [CNT_W-1:0] det_count_d;

    always_comb begin
        det_count_d = det_count_q;
        if (reset) begin
            det_count_d = '0;
        end else if (y && (det_count_q != {CNT_W{1'b1}})) begin
            det_count_d = det_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        det_count_q <= det_count_d;
    end

    assign det_count = det_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
//------------------------------------------------------------------------------
// tb_mealy_seq_detector : self-checking bench for mealy_seq_detector
// Rev 1.0               : initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mealy_seq_detector;

    localparam int         PAT_LEN = 3;
    localparam logic [2:0] PATTERN = 3'b001;
`ifdef MEALY_DET_COUNT_EN
    localparam int         CNT_W   = 2;
`else
    localparam int         CNT_W   = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic y;
`ifdef MEALY_DET_COUNT_EN
    logic [CNT_W-1:0] det_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hist[$];
    int exp_count = 0;

    always #5 clk = ~clk;

    mealy_seq_detector #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (1'b1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
`ifdef MEALY_DET_COUNT_EN
        .det_count (det_count),
`endif
        .y         (y)
    );

    // ---------------- reference model (string matching on received bits)
    function automatic int pat_bit(input int i);
        logic [2:0] p;
        p = PATTERN;
        return int'(p[2'(PAT_LEN - 1 - i)]);
    endfunction

    // Longest pattern prefix (shorter than the full pattern) ending the history.
    function automatic int model_state(input int bits[$]);
        int n;
        bit ok;
        n = bits.size();
        for (int k = PAT_LEN - 1; k >= 1; k--) begin
            if (k <= n) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (bits[n - k + i] != pat_bit(i)) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    function automatic int model_next(input int bits[$], input logic d);
        int tmp[$];
        tmp = bits;
        tmp.push_back(int'(d));
        return model_state(tmp);
    endfunction

    function automatic logic model_y(input int bits[$], input logic d);
        int tmp[$];
        int n;
        tmp = bits;
        tmp.push_back(int'(d));
        n = tmp.size();
        if (n < PAT_LEN) return 1'b0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (tmp[n - PAT_LEN + i] != pat_bit(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- drivers
    task automatic drive_bit(input logic b, output logic y_o, output logic [1:0] ns_o);
        logic e;
        @(negedge clk);
        din = b;
        #1;
        y_o  = y;
        ns_o = dut.nextState;
        e    = model_y(hist, b);
        @(posedge clk);
        #1;
        if (e && exp_count < (1 << CNT_W) - 1) exp_count++;
        hist.push_back(int'(b));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        din   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        hist.delete();
        exp_count = 0;
    endtask

    // ---------------- tests
    task automatic test_reset();
        reset = 1'b1;
        din   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        din = 1'b1;
        #1;
        total_cnt++;
        if (y !== 1'b0) $display("FAIL reset_y: y=%b expected 0", y);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (dut.state !== 2'd0) $display("FAIL reset_state: state=%0d expected 0", dut.state);
        else pass_cnt++;
`ifdef MEALY_DET_COUNT_EN
        total_cnt++;
        if (det_count !== '0) $display("FAIL reset_count: det_count=%0d expected 0", det_count);
        else pass_cnt++;
`endif
        reset = 1'b0;
        hist.delete();
        exp_count = 0;
    endtask

    task automatic test_spec_pattern();
        logic       bits [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ys   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       e;
        logic       got;
        logic [1:0] ns;
        for (int i = 0; i < 6; i++) begin
            e = model_y(hist, bits[i]);
            drive_bit(bits[i], got, ns);
            total_cnt++;
            if (got !== e || got !== ys[i])
                $display("FAIL t1_y bit%0d: y=%b expected %b", i, got, ys[i]);
            else pass_cnt++;
        end
`ifdef MEALY_DET_COUNT_EN
        total_cnt++;
        if (det_count !== CNT_W'(exp_count) || exp_count != 2)
            $display("FAIL t1_count: det_count=%0d expected 2", det_count);
        else pass_cnt++;
`endif
    endtask

    task automatic test_no_match_011();
        logic       bits [3] = '{1'b0, 1'b1, 1'b1};
        int         path [3] = '{1, 0, 0};
        logic       got;
        logic [1:0] ns;
        for (int i = 0; i < 3; i++) begin
            drive_bit(bits[i], got, ns);
            total_cnt++;
            if (got !== 1'b0) $display("FAIL t2_y bit%0d: y=%b expected 0", i, got);
            else pass_cnt++;
            total_cnt++;
            if (dut.state !== 2'(path[i]) || path[i] != model_state(hist))
                $display("FAIL t2_state bit%0d: state=%0d expected %0d", i, dut.state, path[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        logic       got;
        logic [1:0] ns;
        do_reset();
        drive_bit(1'b0, got, ns);
        drive_bit(1'b0, got, ns);
        @(negedge clk);
        reset = 1'b1;
        din   = 1'b1;
        #1;
        total_cnt++;
        if (y !== 1'b0) $display("FAIL t3_y_in_reset: y=%b expected 0", y);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hist.delete();
        exp_count = 0;
        total_cnt++;
        if (dut.state !== 2'd0) $display("FAIL t3_state: state=%0d expected 0", dut.state);
        else pass_cnt++;
        drive_bit(1'b1, got, ns);
        total_cnt++;
        if (got !== 1'b0) $display("FAIL t3_y_after: y=%b expected 0", got);
        else pass_cnt++;
`ifdef MEALY_DET_COUNT_EN
        total_cnt++;
        if (det_count !== '0) $display("FAIL t3_count: det_count=%0d expected 0", det_count);
        else pass_cnt++;
`endif
    endtask

    task automatic test_alt_010();
        logic       bits [3] = '{1'b0, 1'b1, 1'b0};
        int         nsq  [3] = '{1, 0, 1};
        logic       got;
        logic [1:0] ns;
        int         e_ns;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e_ns = model_next(hist, bits[i]);
            drive_bit(bits[i], got, ns);
            total_cnt++;
            if (got !== 1'b0) $display("FAIL t4_y bit%0d: y=%b expected 0", i, got);
            else pass_cnt++;
            total_cnt++;
            if (ns !== 2'(nsq[i]) || e_ns != nsq[i])
                $display("FAIL t4_next bit%0d: nextState=%0d expected %0d", i, ns, nsq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_self_loop();
        logic       bits [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ys   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       got;
        logic [1:0] ns;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_bit(bits[i], got, ns);
            total_cnt++;
            if (got !== ys[i]) $display("FAIL t5_y bit%0d: y=%b expected %b", i, got, ys[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic       b;
        logic       got;
        logic       e_y;
        logic [1:0] ns;
        int         e_ns;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            b    = ($urandom_range(0, 2) == 0);
            e_y  = model_y(hist, b);
            e_ns = model_next(hist, b);
            drive_bit(b, got, ns);
            total_cnt++;
            if (got !== e_y) $display("FAIL rnd_y step%0d: y=%b expected %b", i, got, e_y);
            else pass_cnt++;
            total_cnt++;
            if (ns !== 2'(e_ns)) $display("FAIL rnd_next step%0d: nextState=%0d expected %0d", i, ns, e_ns);
            else pass_cnt++;
`ifdef MEALY_DET_COUNT_EN
            total_cnt++;
            if (det_count !== CNT_W'(exp_count))
                $display("FAIL rnd_count step%0d: det_count=%0d expected %0d", i, det_count, exp_count);
            else pass_cnt++;
`endif
        end
    endtask

`ifdef MEALY_DET_COUNT_EN
    task automatic test_count_saturate();
        logic       got;
        logic [1:0] ns;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            drive_bit(1'b0, got, ns);
            drive_bit(1'b0, got, ns);
            drive_bit(1'b1, got, ns);
            total_cnt++;
            if (det_count !== CNT_W'(exp_count))
                $display("FAIL t6_count rep%0d: det_count=%0d expected %0d", r, det_count, exp_count);
            else pass_cnt++;
        end
        total_cnt++;
        if (det_count !== 2'd3) $display("FAIL t6_saturate: det_count=%0d expected 3", det_count);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (det_count !== 2'd0) $display("FAIL t6_reset: det_count=%0d expected 0", det_count);
        else pass_cnt++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        test_reset();
        test_spec_pattern();
        test_no_match_011();
        test_mid_reset();
        test_alt_010();
        test_self_loop();
        test_random();
`ifdef MEALY_DET_COUNT_EN
        test_count_saturate();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
